// File: rtl/vga_timing_pkg.sv
// Shared types for the VGA frame controller: axis state encodings, config
// addresses and the timing record used for the active and pending banks.
package vga_timing_pkg;

  localparam int CFG_W = 11;

  typedef enum logic [1:0] {
    AX_SYNC  = 2'b00,
    AX_BACK  = 2'b01,
    AX_DISP  = 2'b11,
    AX_FRONT = 2'b10
  } axis_state_t;

  localparam logic [2:0] CFG_H_DISP  = 3'd0;
  localparam logic [2:0] CFG_H_FRONT = 3'd1;
  localparam logic [2:0] CFG_H_SYNC  = 3'd2;
  localparam logic [2:0] CFG_H_BACK  = 3'd3;
  localparam logic [2:0] CFG_V_DISP  = 3'd4;
  localparam logic [2:0] CFG_V_FRONT = 3'd5;
  localparam logic [2:0] CFG_V_SYNC  = 3'd6;
  localparam logic [2:0] CFG_V_BACK  = 3'd7;

  typedef struct packed {
    logic [CFG_W-1:0] disp;
    logic [CFG_W-1:0] front;
    logic [CFG_W-1:0] sync;
    logic [CFG_W-1:0] back;
  } seg_len_t;

  typedef struct packed {
    seg_len_t h;
    seg_len_t v;
  } timing_t;

  function automatic axis_state_t next_axis_state(input axis_state_t s);
    axis_state_t n;
    case (s)
      AX_SYNC: n = AX_BACK;
      AX_BACK: n = AX_DISP;
      AX_DISP: n = AX_FRONT;
      default: n = AX_SYNC;
    endcase
    return n;
  endfunction

  function automatic logic [CFG_W-1:0] clamp_len(input logic [CFG_W-1:0] len);
    return (len == '0) ? CFG_W'(1) : len;
  endfunction

  function automatic seg_len_t clamp_seg(input seg_len_t s);
    seg_len_t c;
    c.disp  = clamp_len(s.disp);
    c.front = clamp_len(s.front);
    c.sync  = clamp_len(s.sync);
    c.back  = clamp_len(s.back);
    return c;
  endfunction

  // Zero-length segments would make the terminal compare unreachable.
  function automatic timing_t clamp_timing(input timing_t t);
    timing_t c;
    c.h = clamp_seg(t.h);
    c.v = clamp_seg(t.v);
    return c;
  endfunction

endpackage

// File: rtl/vga_axis_seq.sv
// One timing axis: walks SYNC -> BACK -> DISP -> FRONT, each segment lasting
// its programmed length, counting up within the segment.
//   state    | meaning
//   AX_SYNC  | sync pulse active
//   AX_BACK  | back porch
//   AX_DISP  | active video, cnt is the pixel/line index
//   AX_FRONT | front porch, last cycle ends the period
module vga_axis_seq
  import vga_timing_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             hold,
  input  seg_len_t         lens,
  output axis_state_t      state,
  output logic [CFG_W-1:0] cnt,
  output logic             last_of_segment,
  output logic             last_of_period
);

  logic [CFG_W-1:0] seg_len;

  always_comb begin
    seg_len = lens.sync;
    case (state)
      AX_BACK:  seg_len = lens.back;
      AX_DISP:  seg_len = lens.disp;
      AX_FRONT: seg_len = lens.front;
      default:  seg_len = lens.sync;
    endcase
  end

  assign last_of_segment = (cnt == seg_len - CFG_W'(1));
  assign last_of_period  = last_of_segment && (state == AX_FRONT);

  always_ff @(posedge clk) begin
    if (rst || hold) begin
      state <= AX_SYNC;
      cnt   <= '0;
    end else if (advance) begin
      if (last_of_segment) begin
        state <= next_axis_state(state);
        cnt   <= '0;
      end else begin
        cnt <= cnt + CFG_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_frame_ctrl.sv
// VGA frame timing controller: H/V axis sequencers, a double-buffered timing
// bank committed only at frame boundaries, and registered pixel-side outputs.
module vga_frame_ctrl
  import vga_timing_pkg::*;
#(
  parameter int W       = CFG_W,
  parameter int H_DISP  = 1280,
  parameter int H_FRONT = 48,
  parameter int H_SYNC  = 112,
  parameter int H_BACK  = 248,
  parameter int V_DISP  = 1024,
  parameter int V_FRONT = 1,
  parameter int V_SYNC  = 3,
  parameter int V_BACK  = 38
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [2:0]   cfg_addr,
  input  logic [W-1:0] cfg_data,
  input  logic         cfg_commit,
  output logic         hsync_n,
  output logic         vsync_n,
  output logic         disp,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         line_start,
  output logic         frame_start
);

  // W is expected to match CFG_W; the bank record is sized by the package.
  localparam timing_t DEF_BANK = '{
    h: '{disp: CFG_W'(H_DISP), front: CFG_W'(H_FRONT),
         sync: CFG_W'(H_SYNC), back: CFG_W'(H_BACK)},
    v: '{disp: CFG_W'(V_DISP), front: CFG_W'(V_FRONT),
         sync: CFG_W'(V_SYNC), back: CFG_W'(V_BACK)}
  };

  timing_t          act_bank;
  timing_t          pend_bank;
  logic             commit_pend;

  axis_state_t      h_state, v_state;
  logic [CFG_W-1:0] h_cnt, v_cnt;
  logic             h_last_period, v_last_period;
  logic             h_seg_end_unused, v_seg_end_unused;
  logic             v_advance, boundary, apply;
  logic             h_start, disp_next;

  vga_axis_seq u_h_axis (
    .clk             (clk),
    .rst             (rst),
    .advance         (en),
    .hold            (!en),
    .lens            (act_bank.h),
    .state           (h_state),
    .cnt             (h_cnt),
    .last_of_segment (h_seg_end_unused),
    .last_of_period  (h_last_period)
  );

  vga_axis_seq u_v_axis (
    .clk             (clk),
    .rst             (rst),
    .advance         (v_advance),
    .hold            (!en),
    .lens            (act_bank.v),
    .state           (v_state),
    .cnt             (v_cnt),
    .last_of_segment (v_seg_end_unused),
    .last_of_period  (v_last_period)
  );

  assign v_advance = en && h_last_period;
  assign boundary  = en && h_last_period && v_last_period;
  // While disabled the axes sit at frame start, so a commit can land at once.
  assign apply     = commit_pend && (!en || boundary);
  assign cfg_ready = !commit_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      act_bank    <= clamp_timing(DEF_BANK);
      pend_bank   <= DEF_BANK;
      commit_pend <= 1'b0;
    end else begin
      if (cfg_valid && cfg_ready) begin
        case (cfg_addr)
          CFG_H_DISP:  pend_bank.h.disp  <= cfg_data;
          CFG_H_FRONT: pend_bank.h.front <= cfg_data;
          CFG_H_SYNC:  pend_bank.h.sync  <= cfg_data;
          CFG_H_BACK:  pend_bank.h.back  <= cfg_data;
          CFG_V_DISP:  pend_bank.v.disp  <= cfg_data;
          CFG_V_FRONT: pend_bank.v.front <= cfg_data;
          CFG_V_SYNC:  pend_bank.v.sync  <= cfg_data;
          default:     pend_bank.v.back  <= cfg_data;
        endcase
      end
      if (apply) begin
        act_bank    <= clamp_timing(pend_bank);
        commit_pend <= 1'b0;
      end else if (cfg_commit && cfg_ready) begin
        commit_pend <= 1'b1;
      end
    end
  end

  assign h_start   = (h_state == AX_SYNC) && (h_cnt == '0);
  assign disp_next = (h_state == AX_DISP) && (v_state == AX_DISP);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      disp        <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync_n     <= (h_state != AX_SYNC);
      vsync_n     <= (v_state != AX_SYNC);
      disp        <= disp_next;
      x           <= disp_next ? h_cnt : '0;
      y           <= disp_next ? v_cnt : '0;
      line_start  <= h_start;
      frame_start <= h_start && (v_state == AX_SYNC) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Self-checking bench for vga_frame_ctrl against a frame-position model.
module tb_vga_frame_ctrl;

  localparam int W = 11;
  localparam logic [27:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst, en, cfg_valid, cfg_commit, cfg_ready;
  logic [2:0] cfg_addr;
  logic [W-1:0] cfg_data;
  logic hsync_n, vsync_n, disp, line_start, frame_start;
  logic [W-1:0] x, y;

  vga_frame_ctrl #(
    .W(W), .H_DISP(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_DISP(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(3)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .disp(disp), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  wire [27:0] got_vec = {hsync_n, vsync_n, disp, x, y, line_start, frame_start, cfg_ready};

  int checks = 0;
  int failures = 0;

  // model: lengths indexed by cfg address, position = (line, pixel) in frame
  int act [8];
  int pb [8];
  bit cp;
  int m_l, m_p;
  logic [27:0] exp_vec;

  int st_disp, st_hs, st_vs, st_fs, st_ls, st_xsum, st_ysum, st_off;

  function automatic int def_len(input int i);
    case (i)
      0: return 8;
      1: return 2;
      2: return 3;
      3: return 4;
      4: return 4;
      5: return 1;
      6: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int htot();
    return act[0] + act[1] + act[2] + act[3];
  endfunction

  function automatic int vtot();
    return act[4] + act[5] + act[6] + act[7];
  endfunction

  function automatic int frame_len();
    return htot() * vtot();
  endfunction

  task automatic model_step();
    int ht, vt;
    bit ready, bnd, apply, h_in, v_in;
    logic e_hs, e_vs, e_disp, e_ls, e_fs;
    logic [W-1:0] e_x, e_y;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        act[i] = def_len(i);
        pb[i]  = def_len(i);
      end
      cp = 1'b0;
      m_l = 0;
      m_p = 0;
      exp_vec = RESET_VEC;
    end else begin
      ht = htot();
      vt = vtot();
      e_hs = 1'b1; e_vs = 1'b1; e_disp = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
      e_x = '0; e_y = '0;
      if (en) begin
        e_hs = !(m_p < act[2]);
        e_vs = !(m_l < act[6]);
        h_in = (m_p >= act[2] + act[3]) && (m_p < act[2] + act[3] + act[0]);
        v_in = (m_l >= act[6] + act[7]) && (m_l < act[6] + act[7] + act[4]);
        e_disp = h_in && v_in;
        if (e_disp) begin
          e_x = W'(m_p - act[2] - act[3]);
          e_y = W'(m_l - act[6] - act[7]);
        end
        e_ls = (m_p == 0);
        e_fs = (m_p == 0) && (m_l == 0);
      end
      ready = !cp;
      bnd = en && (m_l == vt - 1) && (m_p == ht - 1);
      apply = cp && (!en || bnd);
      if (ready && cfg_valid) pb[cfg_addr] = int'(cfg_data);
      if (apply) begin
        for (int i = 0; i < 8; i++) act[i] = (pb[i] == 0) ? 1 : pb[i];
        cp = 1'b0;
      end else if (ready && cfg_commit) begin
        cp = 1'b1;
      end
      if (!en) begin
        m_l = 0;
        m_p = 0;
      end else begin
        m_p++;
        if (m_p == ht) begin
          m_p = 0;
          m_l++;
          if (m_l == vt) m_l = 0;
        end
      end
      exp_vec = {e_hs, e_vs, e_disp, e_x, e_y, e_ls, e_fs, !cp};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (disp) begin
      st_disp++;
      st_xsum += int'(x);
      st_ysum += int'(y);
    end else if (x != '0 || y != '0) begin
      st_off++;
    end
    if (!hsync_n) st_hs++;
    if (!vsync_n) st_vs++;
    if (frame_start) st_fs++;
    if (line_start) st_ls++;
  endtask

  task automatic clear_stats();
    st_disp = 0; st_hs = 0; st_vs = 0; st_fs = 0; st_ls = 0;
    st_xsum = 0; st_ysum = 0; st_off = 0;
  endtask

  task automatic idle();
    cfg_valid = 1'b0;
    cfg_commit = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    repeat (3) begin
      cfg_valid = 1'b1;
      cfg_commit = 1'b1;
      cfg_addr = 3'($urandom_range(0, 7));
      cfg_data = W'($urandom_range(0, 5));
      tick();
      checks++;
      if (got_vec !== RESET_VEC) begin
        failures++;
        $display("FAIL reset_values got=%h exp=%h", got_vec, RESET_VEC);
      end
    end
    idle();
  endtask

  task automatic test_defaults();
    int len;
    rst = 1'b0;
    clear_stats();
    len = frame_len();
    tick();
    checks++;
    if (frame_start !== 1'b1) begin
      failures++;
      $display("FAIL first_frame_start got=%b exp=1", frame_start);
    end
    repeat (2 * len - 1) begin
      tick();
      checks++;
      if (got_vec !== exp_vec) begin
        failures++;
        $display("FAIL defaults got=%h exp=%h", got_vec, exp_vec);
      end
    end
    checks++;
    if (st_disp != 64 || st_hs != 60 || st_vs != 68 || st_fs != 2 || st_ls != 20) begin
      failures++;
      $display("FAIL default_counts got disp=%0d hs=%0d vs=%0d fs=%0d ls=%0d exp 64 60 68 2 20",
               st_disp, st_hs, st_vs, st_fs, st_ls);
    end
    checks++;
    if (st_xsum != 224 || st_ysum != 96 || st_off != 0) begin
      failures++;
      $display("FAIL coords got xsum=%0d ysum=%0d off=%0d exp 224 96 0", st_xsum, st_ysum, st_off);
    end
  endtask

  task automatic test_deferred_commit();
    int len;
    repeat (50) begin
      tick();
      checks++;
      if (got_vec !== exp_vec) begin
        failures++;
        $display("FAIL deferred_pre got=%h exp=%h", got_vec, exp_vec);
      end
    end
    cfg_valid = 1'b1; cfg_addr = 3'd0; cfg_data = W'(4);
    tick();
    cfg_valid = 1'b0; cfg_commit = 1'b1;
    tick();
    idle();
    checks++;
    if (cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL deferred_ready_drop got=%b exp=0", cfg_ready);
    end
    for (int i = 0; i < 400 && cfg_ready !== 1'b1; i++) begin
      tick();
      checks++;
      if (got_vec !== exp_vec) begin
        failures++;
        $display("FAIL deferred_wait got=%h exp=%h", got_vec, exp_vec);
      end
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL deferred_ready_timeout got=%b exp=1", cfg_ready);
    end
    clear_stats();
    len = frame_len();
    repeat (len) begin
      tick();
      checks++;
      if (got_vec !== exp_vec) begin
        failures++;
        $display("FAIL deferred_frame got=%h exp=%h", got_vec, exp_vec);
      end
    end
    checks++;
    if (len != 130 || st_disp != 16 || st_ls != 10 || st_fs != 1) begin
      failures++;
      $display("FAIL deferred_counts got len=%0d disp=%0d ls=%0d fs=%0d exp 130 16 10 1",
               len, st_disp, st_ls, st_fs);
    end
  endtask

  task automatic test_ignored_and_clamp();
    int len;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        cfg_commit = 1'b1;
        tick();
        idle();
        cfg_valid = 1'b1; cfg_addr = 3'd2; cfg_data = W'(9);
        tick();
      end else begin
        cfg_valid = 1'b1; cfg_addr = 3'd6; cfg_data = W'(0);
        tick();
        cfg_valid = 1'b0; cfg_commit = 1'b1;
        tick();
      end
      idle();
      for (int i = 0; i < 400 && cfg_ready !== 1'b1; i++) begin
        tick();
        checks++;
        if (got_vec !== exp_vec) begin
          failures++;
          $display("FAIL ignored_wait got=%h exp=%h", got_vec, exp_vec);
        end
      end
      checks++;
      if (cfg_ready !== 1'b1) begin
        failures++;
        $display("FAIL ignored_ready_timeout got=%b exp=1", cfg_ready);
      end
      clear_stats();
      len = frame_len();
      repeat (len) begin
        tick();
        checks++;
        if (got_vec !== exp_vec) begin
          failures++;
          $display("FAIL ignored_frame got=%h exp=%h", got_vec, exp_vec);
        end
      end
      checks++;
      if (pass == 0 && st_hs != 30) begin
        failures++;
        $display("FAIL hsync_kept got=%0d exp=30", st_hs);
      end else if (pass == 1 && (st_vs != 13 || st_fs != 1 || len != 117)) begin
        failures++;
        $display("FAIL vsync_clamp got vs=%0d fs=%0d len=%0d exp 13 1 117", st_vs, st_fs, len);
      end
    end
  endtask

  task automatic test_same_cycle_and_boundary();
    int len;
    cfg_valid = 1'b1; cfg_commit = 1'b1; cfg_addr = 3'd0; cfg_data = W'(6);
    tick();
    idle();
    for (int i = 0; i < 400 && cfg_ready !== 1'b1; i++) begin
      tick();
      checks++;
      if (got_vec !== exp_vec) begin
        failures++;
        $display("FAIL same_cycle_wait got=%h exp=%h", got_vec, exp_vec);
      end
    end
    clear_stats();
    len = frame_len();
    repeat (len) begin
      tick();
      checks++;
      if (got_vec !== exp_vec) begin
        failures++;
        $display("FAIL same_cycle_frame got=%h exp=%h", got_vec, exp_vec);
      end
    end
    checks++;
    if (st_disp != 24) begin
      failures++;
      $display("FAIL same_cycle_disp got=%0d exp=24", st_disp);
    end
    cfg_valid = 1'b1; cfg_addr = 3'd0; cfg_data = W'(3);
    tick();
    idle();
    for (int i = 0; i < 400 && !(m_l == vtot() - 1 && m_p == htot() - 1); i++) begin
      tick();
      checks++;
      if (got_vec !== exp_vec) begin
        failures++;
        $display("FAIL boundary_seek got=%h exp=%h", got_vec, exp_vec);
      end
    end
    cfg_commit = 1'b1;
    tick();
    idle();
    checks++;
    if (cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL boundary_commit_ready got=%b exp=0", cfg_ready);
    end
    for (int f = 0; f < 2; f++) begin
      clear_stats();
      len = frame_len();
      repeat (len) begin
        tick();
        checks++;
        if (got_vec !== exp_vec) begin
          failures++;
          $display("FAIL boundary_frame got=%h exp=%h", got_vec, exp_vec);
        end
      end
      checks++;
      if (st_disp != ((f == 0) ? 24 : 12)) begin
        failures++;
        $display("FAIL boundary_disp frame=%0d got=%0d exp=%0d", f, st_disp, (f == 0) ? 24 : 12);
      end
    end
  endtask

  task automatic test_enable();
    int len;
    repeat (20) tick();
    en = 1'b0;
    tick();
    checks++;
    if (got_vec !== RESET_VEC) begin
      failures++;
      $display("FAIL disable_outputs got=%h exp=%h", got_vec, RESET_VEC);
    end
    cfg_valid = 1'b1; cfg_commit = 1'b1; cfg_addr = 3'd0; cfg_data = W'(5);
    tick();
    idle();
    tick();
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL disabled_apply got=%b exp=1", cfg_ready);
    end
    repeat (3) begin
      tick();
      checks++;
      if (got_vec !== exp_vec) begin
        failures++;
        $display("FAIL disabled_hold got=%h exp=%h", got_vec, exp_vec);
      end
    end
    clear_stats();
    len = frame_len();
    en = 1'b1;
    tick();
    checks++;
    if (frame_start !== 1'b1) begin
      failures++;
      $display("FAIL enable_frame_start got=%b exp=1", frame_start);
    end
    repeat (len - 1) begin
      tick();
      checks++;
      if (got_vec !== exp_vec) begin
        failures++;
        $display("FAIL enable_frame got=%h exp=%h", got_vec, exp_vec);
      end
    end
    checks++;
    if (st_disp != 20 || st_fs != 1) begin
      failures++;
      $display("FAIL enable_counts got disp=%0d fs=%0d exp 20 1", st_disp, st_fs);
    end
  endtask

  task automatic test_reset_mid();
    int len;
    repeat (30) tick();
    cfg_valid = 1'b1; cfg_addr = 3'd0; cfg_data = W'(2);
    tick();
    cfg_addr = 3'd4; cfg_commit = 1'b1;
    tick();
    idle();
    repeat (5) tick();
    rst = 1'b1;
    repeat (2) begin
      tick();
      checks++;
      if (got_vec !== RESET_VEC) begin
        failures++;
        $display("FAIL midreset_values got=%h exp=%h", got_vec, RESET_VEC);
      end
    end
    rst = 1'b0;
    for (int f = 0; f < 2; f++) begin
      if (f == 1) begin
        cfg_commit = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 400 && cfg_ready !== 1'b1; i++) tick();
      end
      clear_stats();
      len = frame_len();
      repeat (len) begin
        tick();
        checks++;
        if (got_vec !== exp_vec) begin
          failures++;
          $display("FAIL midreset_frame got=%h exp=%h", got_vec, exp_vec);
        end
      end
      checks++;
      if (st_disp != 32 || st_fs != 1) begin
        failures++;
        $display("FAIL midreset_counts frame=%0d got disp=%0d fs=%0d exp 32 1", f, st_disp, st_fs);
      end
    end
  endtask

  task automatic test_random();
    repeat (3000) begin
      rst = ($urandom_range(0, 599) == 0);
      en = ($urandom_range(0, 15) != 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_commit = ($urandom_range(0, 39) == 0);
      cfg_addr = 3'($urandom_range(0, 7));
      cfg_data = W'($urandom_range(0, 5));
      tick();
      checks++;
      if (got_vec !== exp_vec) begin
        failures++;
        $display("FAIL random got=%h exp=%h", got_vec, exp_vec);
      end
    end
    rst = 1'b0;
    en = 1'b1;
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en = 1'b1;
    idle();
    clear_stats();
    test_reset();
    test_defaults();
    test_deferred_commit();
    test_ignored_and_clamp();
    test_same_cycle_and_boundary();
    test_enable();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
